// File: rtl/caravel_io_pkg.sv
// caravel_io_pkg
// Shared constants for the Caravel user-area I/O bridge: register word
// offsets inside the 256-byte window, IRQ_MAP source encodings, the pad
// output-enable reset value, and the Wishbone byte-lane mask helper.
package caravel_io_pkg;

   localparam logic [7:0] OFF_OUT_LO     = 8'h00;
   localparam logic [7:0] OFF_OUT_HI     = 8'h04;
   localparam logic [7:0] OFF_OEB_LO     = 8'h08;
   localparam logic [7:0] OFF_OEB_HI     = 8'h0C;
   localparam logic [7:0] OFF_IN_LO      = 8'h10;
   localparam logic [7:0] OFF_IN_HI      = 8'h14;
   localparam logic [7:0] OFF_EDGE_EN_LO = 8'h18;
   localparam logic [7:0] OFF_EDGE_EN_HI = 8'h1C;
   localparam logic [7:0] OFF_PEND_LO    = 8'h20;
   localparam logic [7:0] OFF_PEND_HI    = 8'h24;
   localparam logic [7:0] OFF_IRQ_MAP    = 8'h28;

   localparam logic [1:0] IRQ_SRC_OFF = 2'd0;
   localparam logic [1:0] IRQ_SRC_LO  = 2'd1;
   localparam logic [1:0] IRQ_SRC_HI  = 2'd2;
   localparam logic [1:0] IRQ_SRC_ANY = 2'd3;

   // All pads come out of reset as inputs (output drivers disabled).
   localparam logic [63:0] OEB_RST = {64{1'b1}};

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge
// Two-flop synchroniser for asynchronous pad inputs plus a third flop that
// holds the previous synchronised sample, giving a one-cycle rise pulse.
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      synchronous active-low reset
//   d      in  WIDTH  asynchronous pad inputs
//   sync   out WIDTH  synchronised inputs
//   rise   out WIDTH  sync & ~previous sample
module io_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;
   logic [WIDTH-1:0] prev_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         prev_p2 <= '0;
      end else begin
         // p0: metastability capture
         sync_p0 <= d;
         // p1: settled sample
         sync_p1 <= sync_p0;
         // p2: previous settled sample for edge detection
         prev_p2 <= sync_p1;
      end
   end

   assign sync = sync_p1;
   assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/caravel_io_bridge.sv
// caravel_io_bridge
// Wishbone classic slave owning the user-area pads: programmable OUT/OEB
// registers, synchronised IN sampling, per-pad rising-edge PEND capture
// (write-1-to-clear, set wins over clear) and routing of PEND onto user_irq.
// Ports:
//   wb_clk_i, wb_rst_ni              clock / synchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i   Wishbone request
//   wbs_dat_o, wbs_ack_o             Wishbone response (registered)
//   io_in                            asynchronous pad inputs
//   io_out, io_oeb                   pad output value / active-low enable
//   user_irq                         interrupts to the management core
module caravel_io_bridge
   import caravel_io_pkg::*;
#(
   parameter int          N_IO      = 38,
   parameter int          N_IRQ     = 3,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic [31:0]       wbs_dat_o,
   output logic              wbs_ack_o,
   input  logic [N_IO-1:0]   io_in,
   output logic [N_IO-1:0]   io_out,
   output logic [N_IO-1:0]   io_oeb,
   output logic [N_IRQ-1:0]  user_irq
);

   logic [N_IO-1:0]    out_q, oeb_q, edge_en_q, pend_q;
   logic [N_IO-1:0]    out_d, oeb_d, edge_en_d, pend_d;
   logic [2*N_IRQ-1:0] irq_map_q, irq_map_d;
   logic [N_IRQ-1:0]   irq_q, irq_d;
   logic               ack_q;
   logic [31:0]        dat_q, rdata;
   logic [N_IO-1:0]    in_sync, in_rise;

   logic               req, hit, wr;
   logic [7:0]         off;
   logic [31:0]        lmask;
   logic [63:0]        out64, oeb64, in64, een64, pend64, map64;
   logic [63:0]        out_w, oeb_w, een_w, map_w, clr_w;

   io_sync_edge #(.WIDTH(N_IO)) u_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .d     (io_in),
      .sync  (in_sync),
      .rise  (in_rise)
   );

   // Merge a 32-bit byte-laned write into the LO or HI half of a 64-bit view;
   // bits beyond the real register width are dropped when sliced back.
   function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] d,
                                         input logic [31:0] m, input logic hi);
      merge = old;
      if (hi) merge[63:32] = (old[63:32] & ~m) | (d & m);
      else    merge[31:0]  = (old[31:0]  & ~m) | (d & m);
   endfunction

   assign req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
   assign hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off   = wbs_adr_i[7:0];
   assign wr    = req & hit & wbs_we_i;
   assign lmask = lane_mask(wbs_sel_i);

   assign out64  = 64'(out_q);
   assign oeb64  = 64'(oeb_q);
   assign in64   = 64'(in_sync);
   assign een64  = 64'(edge_en_q);
   assign pend64 = 64'(pend_q);
   assign map64  = 64'(irq_map_q);

   always_comb begin
      out_w = out64;
      oeb_w = oeb64;
      een_w = een64;
      map_w = map64;
      clr_w = '0;
      if (wr) begin
         case (off)
            OFF_OUT_LO:     out_w = merge(out64, wbs_dat_i, lmask, 1'b0);
            OFF_OUT_HI:     out_w = merge(out64, wbs_dat_i, lmask, 1'b1);
            OFF_OEB_LO:     oeb_w = merge(oeb64, wbs_dat_i, lmask, 1'b0);
            OFF_OEB_HI:     oeb_w = merge(oeb64, wbs_dat_i, lmask, 1'b1);
            OFF_EDGE_EN_LO: een_w = merge(een64, wbs_dat_i, lmask, 1'b0);
            OFF_EDGE_EN_HI: een_w = merge(een64, wbs_dat_i, lmask, 1'b1);
            OFF_PEND_LO:    clr_w = merge(64'd0, wbs_dat_i, lmask, 1'b0);
            OFF_PEND_HI:    clr_w = merge(64'd0, wbs_dat_i, lmask, 1'b1);
            OFF_IRQ_MAP:    map_w = merge(map64, wbs_dat_i, lmask, 1'b0);
            default: ;
         endcase
      end
   end

   assign out_d     = out_w[N_IO-1:0];
   assign oeb_d     = oeb_w[N_IO-1:0];
   assign edge_en_d = een_w[N_IO-1:0];
   assign irq_map_d = map_w[2*N_IRQ-1:0];
   // Clear first, then OR in new edges so a coincident rise is never lost.
   assign pend_d    = (pend_q & ~clr_w[N_IO-1:0]) | (in_rise & edge_en_q);

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (off)
            OFF_OUT_LO:     rdata = out64[31:0];
            OFF_OUT_HI:     rdata = out64[63:32];
            OFF_OEB_LO:     rdata = oeb64[31:0];
            OFF_OEB_HI:     rdata = oeb64[63:32];
            OFF_IN_LO:      rdata = in64[31:0];
            OFF_IN_HI:      rdata = in64[63:32];
            OFF_EDGE_EN_LO: rdata = een64[31:0];
            OFF_EDGE_EN_HI: rdata = een64[63:32];
            OFF_PEND_LO:    rdata = pend64[31:0];
            OFF_PEND_HI:    rdata = pend64[63:32];
            OFF_IRQ_MAP:    rdata = map64[31:0];
            default:        rdata = '0;
         endcase
      end
   end

   always_comb begin
      irq_d = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         case (irq_map_q[2*k +: 2])
            IRQ_SRC_LO:  irq_d[k] = |pend64[31:0];
            IRQ_SRC_HI:  irq_d[k] = |pend64[63:32];
            IRQ_SRC_ANY: irq_d[k] = |pend64;
            default:     irq_d[k] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         out_q     <= '0;
         oeb_q     <= OEB_RST[N_IO-1:0];
         edge_en_q <= '0;
         pend_q    <= '0;
         irq_map_q <= '0;
         irq_q     <= '0;
      end else begin
         ack_q     <= req;
         dat_q     <= (req & ~wbs_we_i) ? rdata : 32'd0;
         out_q     <= out_d;
         oeb_q     <= oeb_d;
         edge_en_q <= edge_en_d;
         pend_q    <= pend_d;
         irq_map_q <= irq_map_d;
         irq_q     <= irq_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = out_q;
   assign io_oeb    = oeb_q;
   assign user_irq  = irq_q;

endmodule

// File: doc/caravel_io_bridge.md
# caravel_io_bridge

Wishbone-slave I/O controller that sits between the Caravel management Wishbone bus and the user-area pads. It is a parametrised successor to the fixed pass-through of `io_in`/`io_out`/`io_oeb` and `user_irq`: software-programmable per-pad output and output-enable registers, synchronised pad input sampling, per-pad rising-edge interrupt capture with write-1-to-clear pending bits, and interrupt routing onto `user_irq`. It is instantiated in `user_project_wrapper` next to the SoC core and owns any pads the core does not claim.

## Interface
- `N_IO`, 38: number of pads managed, 1..64.
- `N_IRQ`, 3: width of `user_irq`, 1..4.
- `BASE_ADDR`, 32'h3000_0000: Wishbone base; decode on `wbs_adr_i[31:8]`.
- `wb_clk_i`  in  1  clock; all logic on the rising edge.
- `wb_rst_ni`  in  1  reset; synchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe/cycle/write.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_dat_o`  out  32  read data.
- `wbs_ack_o`  out  1  acknowledge.
- `io_in`  in  N_IO  pad inputs (asynchronous).
- `io_out`  out  N_IO  pad output values.
- `io_oeb`  out  N_IO  pad output-enable, active-low.
- `user_irq`  out  N_IRQ  interrupts to management core.

## Operation
- Registers (word offsets; LO = bits 31:0, HI = bits N_IO-1:32): 0x00/0x04 OUT (RW), 0x08/0x0C OEB (RW), 0x10/0x14 IN (RO), 0x18/0x1C EDGE_EN (RW), 0x20/0x24 PEND (W1C), 0x28 IRQ_MAP (RW; 2 bits per IRQ line, bit 2k+1:2k selects source for `user_irq[k]`: 0=off, 1=any PEND LO, 2=any PEND HI, 3=any PEND).
- Bits at or above N_IO read 0 and ignore writes; unmapped offsets and base mismatches read 0, writes dropped, still acknowledged.
- Byte lanes: writes update only bytes with `wbs_sel_i` set; reads return the full word regardless of `wbs_sel_i`.
- Input path: each `io_in` bit passes through a 2-flop synchroniser, then a third flop holds the previous sample; rise = sync & ~prev.
- PEND[i] sets on rise[i] & EDGE_EN[i]; cleared by writing 1. Same-cycle set and clear: set wins.
- `user_irq[k]` = registered OR-reduce of the source selected by IRQ_MAP.
- Reset values: OUT=0, OEB=all ones (all pads input), EDGE_EN=0, PEND=0, IRQ_MAP=0, synchroniser flops 0, `wbs_ack_o`=0, `wbs_dat_o`=0, `user_irq`=0, `io_out`=0, `io_oeb`=all ones.

## Timing
- Handshake: request = `wbs_cyc_i & wbs_stb_i & ~wbs_ack_o`. `wbs_ack_o` is registered, high exactly one cycle, asserted the cycle after the request is seen; `wbs_dat_o` valid in that cycle, 0 otherwise.
- Back-to-back: a held strobe produces an ack every second cycle (req, ack, req, ack...).
- Write side effects land on the edge that raises `wbs_ack_o`; `io_out`/`io_oeb` change in the ack cycle.
- Pad rising edge to IN visible: 2 cycles; to PEND set: 3 cycles; to `user_irq`: 4 cycles.
- Reset asserted mid-transaction: ack suppressed, all state to reset values the next edge; master must re-issue.
- `wbs_cyc_i` dropped before ack: pending ack still fires one cycle; it is ignored by the master and causes no side effect beyond the already-decided write.

## Structure
- Package `caravel_io_pkg`: register offset constants, IRQ_MAP source encodings, reset value of OEB.
- Sub-module `io_sync_edge` (parameter WIDTH): 2-flop synchroniser plus previous-sample flop, outputs `sync` and `rise`; one instance of width N_IO.
- Top holds the Wishbone decoder, register file, PEND logic and IRQ mux.

## Test plan
- Reset release -> `io_oeb`=38'h3F_FFFF_FFFF, `io_out`=0, `user_irq`=0, read OEB_LO returns 32'hFFFF_FFFF.
- Write OUT_LO=32'hA5A5_A5A5 with sel=4'b0011 -> `io_out[31:0]`=32'h0000_A5A5 in the ack cycle; ack high exactly one cycle.
- Write OUT_HI=32'hFFFF_FFFF with N_IO=38 -> `io_out[37:32]`=6'h3F, read-back 32'h0000_003F.
- EDGE_EN_LO bit 5=1, IRQ_MAP=2'b01, pulse `io_in[5]` 0->1 -> PEND_LO=32'h20 after 3 cycles, `user_irq[0]`=1 after 4; write PEND_LO=32'h20 -> `user_irq[0]`=0.
- Rising edge on `io_in[5]` arriving the same cycle as W1C of bit 5 -> PEND_LO bit 5 remains 1.
- Read address 32'h3000_0040 and 32'h3100_0000 -> ack after one cycle, data 0, no register changed.
